// File: rtl/tinyalu_pkg.sv
// Shared TinyALU definitions: opcode encoding and opcode classification.
// No latency or flow control of its own; used by the command master.
package tinyalu_pkg;

    typedef enum logic [2:0] {
        no_op  = 3'b000,
        add_op = 3'b001,
        and_op = 3'b010,
        xor_op = 3'b011,
        mul_op = 3'b100,
        rst_op = 3'b111
    } operation_t;

    // True for opcodes that start the ALU and wait for alu_done.
    function automatic logic needs_alu(input logic [2:0] op);
        return (op == add_op) || (op == and_op) || (op == xor_op) || (op == mul_op);
    endfunction

endpackage

// File: rtl/alu_wdog_counter.sv
// Wait-cycle watchdog: counts enabled cycles, flags the LIMIT-th one combinationally.
// Single-cycle clear; no backpressure, expired holds the count until cleared.
module alu_wdog_counter #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = $clog2(LIMIT + 1);
    localparam logic [W-1:0] LAST = W'(LIMIT - 1);

    logic [W-1:0] cnt_q, cnt_d;

    assign expired = enable && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && !expired) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/alu_cmd_master.sv
// One-outstanding-command master for TinyALU; response d+2 cycles after accept (2 no_op, 3 rst_op).
// Holds the response until rsp_ready; accepts a new command only in IDLE.
module alu_cmd_master
    import tinyalu_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [7:0]  cmd_a,
    input  logic [7:0]  cmd_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_result,
    output logic [2:0]  rsp_op,
    output logic        rsp_err,
    output logic        alu_start,
    output logic [2:0]  alu_op,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    input  logic        alu_done,
    input  logic [15:0] alu_result,
    output logic        alu_reset_n
);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_DONE, ALU_RST, RESP} state_t;

    state_t      state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [7:0]  a_q, a_d;
    logic [7:0]  b_q, b_d;
    logic [15:0] result_q, result_d;
    logic        err_q, err_d;
    logic        rst_cnt_q, rst_cnt_d;
    logic        alu_rst_n_q;
    logic        wdog_expired;

    alu_wdog_counter #(.LIMIT(TIMEOUT)) u_wdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (state_q == ISSUE),
        .enable  (state_q == WAIT_DONE),
        .expired (wdog_expired)
    );

    assign cmd_ready   = (state_q == IDLE) && !reset;
    assign rsp_valid   = (state_q == RESP);
    assign rsp_result  = result_q;
    assign rsp_op      = op_q;
    assign rsp_err     = err_q;
    assign alu_start   = (state_q == ISSUE) || (state_q == WAIT_DONE);
    // Illegal encodings behave as no_op towards the ALU but are echoed raw on rsp_op.
    assign alu_op      = needs_alu(op_q) ? op_q : 3'(no_op);
    assign alu_a       = a_q;
    assign alu_b       = b_q;
    assign alu_reset_n = alu_rst_n_q && (state_q != ALU_RST);

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        result_d  = result_q;
        err_d     = err_q;
        rst_cnt_d = rst_cnt_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    op_d      = cmd_op;
                    a_d       = cmd_a;
                    b_d       = cmd_b;
                    result_d  = '0;
                    err_d     = 1'b0;
                    rst_cnt_d = 1'b0;
                    state_d   = (cmd_op == rst_op) ? ALU_RST : ISSUE;
                end
            end
            ISSUE: begin
                state_d = needs_alu(op_q) ? WAIT_DONE : RESP;
            end
            WAIT_DONE: begin
                // alu_done takes priority over a simultaneous timeout.
                if (alu_done) begin
                    result_d = alu_result;
                    err_d    = 1'b0;
                    state_d  = RESP;
                end else if (wdog_expired) begin
                    result_d = '0;
                    err_d    = 1'b1;
                    state_d  = RESP;
                end
            end
            ALU_RST: begin
                rst_cnt_d = 1'b1;
                if (rst_cnt_q) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            op_q        <= 3'(no_op);
            a_q         <= '0;
            b_q         <= '0;
            result_q    <= '0;
            err_q       <= 1'b0;
            rst_cnt_q   <= 1'b0;
            alu_rst_n_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            result_q    <= result_d;
            err_q       <= err_d;
            rst_cnt_q   <= rst_cnt_d;
            alu_rst_n_q <= 1'b1;
        end
    end

endmodule
